sram_responder: RTL and testbench

Synthesizable memory-side responder for the SLC-3 external SRAM bus. The CPU drives the active-low chip, output, write and byte-lane strobes, the 20-bit address and the shared 16-bit data bus; this block answers as the SRAM. Reads are served from an internal word array one clock after the request, and writes are committed once per write strobe. It replaces the behavioural memory model so that the SLC-3 top level can be simulated and synthesized with real on-chip memory.

---
 rtl/sram_responder_if.sv | 21 ++
 rtl/sram_responder.sv | 149 ++++++++++++++
 tb/tb_sram_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// Strobe and address bundle of the SLC-3 external SRAM bus.
//   CE, OE, WE  chip / output / write enables, active-low
//   UB, LB      upper / lower byte-lane enables, active-low
//   ADDR[19:0]  word address
// The shared 16-bit data bus is tri-state and is carried as a separate inout
// port on the responder, so that the bus resolution lives on a plain net.
// Modports: master = CPU side (drives everything), slave = memory side.
// -----------------------------------------------------------------------------
interface sram_responder_if;
   logic        CE;
   logic        OE;
   logic        WE;
   logic        UB;
   logic        LB;
   logic [19:0] ADDR;

   modport master (output CE, OE, WE, UB, LB, ADDR);
   modport slave  (input  CE, OE, WE, UB, LB, ADDR);
endinterface

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Memory-side responder for the SLC-3 external SRAM bus, backed by an on-chip
// array of 2^ADDR_W 16-bit words. Reads return data one clock after the
// request is sampled; writes commit once per write strobe.
//
// Ports
//   Clk       system clock, rising edge
//   Reset     synchronous reset, active-low
//   bus       strobes + address (sram_responder_if.slave)
//   Data      shared 16-bit data bus, driven only while a read is served
//   oor_err   sticky: an access addressed beyond the array (ADDR[19:ADDR_W]!=0)
//   rd_count  reads started   (only with SRAM_RESP_STATS_EN defined)
//   wr_count  writes started  (only with SRAM_RESP_STATS_EN defined)
//
// Optional feature macro: SRAM_RESP_STATS_EN (transaction counters).
// -----------------------------------------------------------------------------
module sram_responder #(
   parameter int ADDR_W = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   sram_responder_if.slave    bus,
   inout  wire  [15:0]        Data,
   output logic               oor_err
`ifdef SRAM_RESP_STATS_EN
   ,
   output logic [15:0]        rd_count,
   output logic [15:0]        wr_count
`endif
);

   typedef enum logic [1:0] {IDLE, READ, WHOLD} state_t;

   logic [15:0]       mem [2**ADDR_W];

   state_t            state_q, state_d;
   logic [15:0]       rd_q, rd_d;
   logic              oor_q;
   // Blocks a write whose strobe was already low across reset, so that
   // releasing reset mid-write does not commit the word a second time.
   logic              wr_hold_q;

   logic              req_wr, req_rd, in_range;
   logic              load_rd, do_wr;
   logic [ADDR_W-1:0] idx;
   logic [15:0]       word;

   assign req_wr   = !bus.CE && !bus.WE;
   assign req_rd   = !bus.CE &&  bus.WE && !bus.OE;
   assign in_range = (bus.ADDR[19:ADDR_W] == '0);
   assign idx      = bus.ADDR[ADDR_W-1:0];
   assign word     = mem[idx];

   always_comb begin
      state_d = state_q;
      load_rd = 1'b0;
      do_wr   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_rd) begin
               load_rd = 1'b1;
               state_d = READ;
            end else if (req_wr && !wr_hold_q) begin
               do_wr   = 1'b1;
               state_d = WHOLD;
            end
         end
         READ: begin
            if (req_rd) begin
               load_rd = 1'b1;
            end else if (req_wr) begin
               do_wr   = 1'b1;
               state_d = WHOLD;
            end else begin
               state_d = IDLE;
            end
         end
         WHOLD: begin
            if (!req_wr) begin
               if (req_rd) begin
                  load_rd = 1'b1;
                  state_d = READ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Disabled lanes read as zero; out-of-range reads return all zeros.
   always_comb begin
      rd_d = {bus.UB ? 8'h00 : word[15:8], bus.LB ? 8'h00 : word[7:0]};
      if (!in_range) begin
         rd_d = 16'h0000;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= IDLE;
         rd_q      <= '0;
         oor_q     <= 1'b0;
         wr_hold_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_hold_q <= wr_hold_q && req_wr;
         if (load_rd) begin
            rd_q <= rd_d;
         end
         if ((load_rd || do_wr) && !in_range) begin
            oor_q <= 1'b1;
         end
      end
   end

   // Array is never cleared; only enabled, in-range lanes are committed.
   always_ff @(posedge Clk) begin
      if (Reset && do_wr && in_range) begin
         if (!bus.UB) mem[idx][15:8] <= Data[15:8];
         if (!bus.LB) mem[idx][7:0]  <= Data[7:0];
      end
   end

   // Release is combinational on the strobes so the bus turns around at once.
   assign Data    = (state_q == READ && req_rd) ? rd_q : 16'hzzzz;
   assign oor_err = oor_q;

`ifdef SRAM_RESP_STATS_EN
   logic [15:0] rd_count_q, wr_count_q;

   // Count entries into a state, not cycles spent there.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (state_d == READ  && state_q != READ)  rd_count_q <= rd_count_q + 16'd1;
         if (state_d == WHOLD && state_q != WHOLD) wr_count_q <= wr_count_q + 16'd1;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Scoreboard bench: each read pushes its expected word when the request is
// driven; the word is popped and compared against Data one clock later.
// Data carries pull-ups, so a released bus reads as 16'hFFFF (no test word
// uses that value).
// -----------------------------------------------------------------------------
module tb_sram_responder;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset;
   logic        oor_err;
   logic [15:0] drv;
   logic        drv_en;
   wire  [15:0] Data_w;

   sram_responder_if bus ();

   assign Data_w = drv_en ? drv : 16'hzzzz;

   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (Data_w[g]);
   end

`ifdef SRAM_RESP_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   sram_responder #(.ADDR_W(10)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .bus     (bus.slave),
      .Data    (Data_w),
      .oor_err (oor_err)
`ifdef SRAM_RESP_STATS_EN
      ,
      .rd_count(rd_count),
      .wr_count(wr_count)
`endif
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.CE = 1'b1;
      bus.OE = 1'b1;
      bus.WE = 1'b1;
      bus.UB = 1'b0;
      bus.LB = 1'b0;
      drv_en = 1'b0;
   endtask

   task automatic wr_drive(input logic [19:0] a, input logic [15:0] d,
                           input logic ub, input logic lb);
      bus.CE   = 1'b0;
      bus.WE   = 1'b0;
      bus.OE   = 1'b1;
      bus.UB   = ub;
      bus.LB   = lb;
      bus.ADDR = a;
      drv      = d;
      drv_en   = 1'b1;
   endtask

   // Single write strobe followed by a release cycle.
   task automatic wr(input logic [19:0] a, input logic [15:0] d,
                     input logic ub, input logic lb);
      wr_drive(a, d, ub, lb);
      tick();
      bus_idle();
      tick();
   endtask

   // Issue a read request and compare the word one clock later; the request
   // is left asserted so reads can stream.
   task automatic rd(input logic [19:0] a, input logic ub, input logic lb,
                     input logic [15:0] e, input string tag);
      logic [15:0] want;
      bus.CE   = 1'b0;
      bus.OE   = 1'b0;
      bus.WE   = 1'b1;
      bus.UB   = ub;
      bus.LB   = lb;
      bus.ADDR = a;
      drv_en   = 1'b0;
      exp_q.push_back(e);
      tick();
      want = exp_q.pop_front();
      chk(tag, Data_w, want);
   endtask

   initial begin
      bus_idle();
      bus.ADDR = '0;
      drv      = '0;
      Reset    = 1'b0;
      tick();
      tick();
      chk("rst_oor", oor_err, 0);
      chk("rst_data", Data_w, 16'hFFFF);
      // A read request while reset is held must not drive the bus.
      bus.CE = 1'b0;
      bus.OE = 1'b0;
      tick();
      chk("rst_rd_released", Data_w, 16'hFFFF);
`ifdef SRAM_RESP_STATS_EN
      chk("rst_rdcnt", rd_count, 0);
      chk("rst_wrcnt", wr_count, 0);
`endif
      bus_idle();
      Reset = 1'b1;
      tick();

      // Write then read.
      wr(20'h00010, 16'h1234, 1'b0, 1'b0);
      rd(20'h00010, 1'b0, 1'b0, 16'h1234, "wr_rd");
      bus_idle();
      tick();

      // Byte lanes.
      wr(20'h00020, 16'hAAAA, 1'b0, 1'b0);
      wr(20'h00020, 16'h5555, 1'b1, 1'b0);
      rd(20'h00020, 1'b0, 1'b1, 16'hAA00, "lane_ub_only");
      bus_idle();
      tick();
      rd(20'h00020, 1'b1, 1'b0, 16'h0055, "lane_lb_only");
      rd(20'h00020, 1'b0, 1'b0, 16'hAA55, "lane_full");
      // Write straight out of READ, then read it back.
      wr(20'h00021, 16'h0F0F, 1'b0, 1'b0);
      rd(20'h00021, 1'b0, 1'b0, 16'h0F0F, "read_to_write");
      bus_idle();
      tick();
      wr(20'h00021, 16'h7777, 1'b1, 1'b1);
      rd(20'h00021, 1'b0, 1'b0, 16'h0F0F, "no_lane_write");
      bus_idle();
      tick();

      // Streaming read and bus turnaround.
      wr(20'h00000, 16'h000A, 1'b0, 1'b0);
      wr(20'h00001, 16'h000B, 1'b0, 1'b0);
      wr(20'h00002, 16'h000C, 1'b0, 1'b0);
      rd(20'h00000, 1'b0, 1'b0, 16'h000A, "stream0");
      rd(20'h00001, 1'b0, 1'b0, 16'h000B, "stream1");
      rd(20'h00002, 1'b0, 1'b0, 16'h000C, "stream2");
      bus.OE = 1'b1;
      #1;
      chk("turn_oe", Data_w, 16'hFFFF);
      bus_idle();
      tick();
      rd(20'h00002, 1'b0, 1'b0, 16'h000C, "stream_again");
      bus.CE = 1'b1;
      #1;
      chk("turn_ce", Data_w, 16'hFFFF);
      bus_idle();
      tick();

      // Out of range.
      chk("oor_pre", oor_err, 0);
      wr_drive(20'h00400, 16'hBEEF, 1'b0, 1'b0);
      tick();
      chk("oor_set", oor_err, 1);
      bus_idle();
      tick();
      rd(20'h00000, 1'b0, 1'b0, 16'h000A, "oor_no_alias");
      bus_idle();
      tick();
      rd(20'h00400, 1'b0, 1'b0, 16'h0000, "oor_read_zero");
      bus_idle();
      tick();
      chk("oor_sticky", oor_err, 1);

      // Reset mid-read.
      rd(20'h00010, 1'b0, 1'b0, 16'h1234, "pre_reset_rd");
      Reset = 1'b0;
      tick();
      chk("rst_mid_rd_data", Data_w, 16'hFFFF);
      chk("rst_mid_rd_oor", oor_err, 0);
`ifdef SRAM_RESP_STATS_EN
      chk("rst_mid_rdcnt", rd_count, 0);
      chk("rst_mid_wrcnt", wr_count, 0);
`endif
      Reset = 1'b1;
      bus_idle();
      tick();
      rd(20'h00010, 1'b0, 1'b0, 16'h1234, "post_rst_10");
      bus_idle();
      tick();
      rd(20'h00020, 1'b0, 1'b0, 16'hAA55, "post_rst_20");
      bus_idle();
      tick();

      // Write hold: only the first word of a held strobe is stored.
      wr_drive(20'h00030, 16'h0001, 1'b0, 1'b0);
      tick();
      drv = 16'h0002;
      tick();
      drv = 16'h0003;
      tick();
      bus_idle();
      tick();
`ifdef SRAM_RESP_STATS_EN
      chk("hold_wrcnt", wr_count, 1);
`endif
      rd(20'h00030, 1'b0, 1'b0, 16'h0001, "write_hold");
      bus_idle();
      tick();

      // Reset during a held write must not rewrite the word on release.
      wr_drive(20'h00040, 16'h1111, 1'b0, 1'b0);
      tick();
      Reset = 1'b0;
      drv   = 16'h2222;
      tick();
      Reset = 1'b1;
      tick();
      bus_idle();
      tick();
      rd(20'h00040, 1'b0, 1'b0, 16'h1111, "rst_in_whold");
      bus_idle();
      tick();
      wr(20'h00041, 16'h4141, 1'b0, 1'b0);
      rd(20'h00041, 1'b0, 1'b0, 16'h4141, "wr_after_rst");
      bus_idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
